frame_capture_ctrl: RTL and testbench

//  Frame-level capture sequencer on the clk-domain camera byte stream, placed between the
//  OV7670 frame reader's AXI-Stream output and the DMA/VDMA input.

---
 rtl/frame_capture_ctrl_pkg.sv | 25 ++
 rtl/frame_capture_ctrl_if.sv | 44 ++++
 rtl/frame_capture_ctrl_byte_counter.sv | 37 +++
 rtl/frame_capture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_ctrl_pkg
//  Description : Shared definitions for the camera frame capture slice:
//                sequencer state encoding and default frame geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package frame_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PAD     = 3'd3,
        ST_DRAIN   = 3'd4
    } cap_state_t;

    // Default geometry: VGA, RGB565
    localparam int c_h_pix               = 640;
    localparam int c_v_lines             = 480;
    localparam int c_bytes_per_pix       = 2;
    localparam int c_frame_bytes_default = c_h_pix * c_v_lines * c_bytes_per_pix;

endpackage : frame_capture_ctrl_pkg
`default_nettype wire

// File: rtl/frame_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_ctrl_if
//  Description : Command, stream and status bundle of the frame capture
//                sequencer.
//                master : environment side (commands, source stream, DMA ready)
//                slave  : sequencer side
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_capture_ctrl_if #(
    parameter int FCNT_W = 16
);
    logic              frame_sync;
    logic              cmd_start;
    logic              cmd_stop;
    logic              cmd_cont;
    logic [7:0]        s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [7:0]        m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;
    logic              err_short;
    logic              err_long;

    modport master (
        output frame_sync, cmd_start, cmd_stop, cmd_cont,
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast,
        input  busy, frame_cnt, err_short, err_long
    );

    modport slave (
        input  frame_sync, cmd_start, cmd_stop, cmd_cont,
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast,
        output busy, frame_cnt, err_short, err_long
    );

endinterface : frame_capture_ctrl_if
`default_nettype wire

// File: rtl/frame_capture_ctrl_byte_counter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_ctrl_byte_counter
//  Description : Byte position within the current frame. Clear has priority
//                over count; o_is_last flags position FRAME_BYTES-1.
//  Ports       : clk, RESETn (sync, active-low), i_clear, i_en, o_is_last
//  Revision    : 1.0  initial release
// ============================================================================
module frame_capture_ctrl_byte_counter #(
    parameter int FRAME_BYTES = 614400,
    parameter int CNT_W       = 20
) (
    input  wire logic clk,
    input  wire logic RESETn,
    input  wire logic i_clear,
    input  wire logic i_en,
    output logic      o_is_last
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(FRAME_BYTES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_is_last = (r_cnt == c_last);

endmodule : frame_capture_ctrl_byte_counter
`default_nettype wire

// File: rtl/frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_capture_ctrl
//  Description : Frame-level capture sequencer between the camera byte stream
//                and the DMA. Aligns to VSYNC, forwards exactly FRAME_BYTES
//                bytes per frame with tlast on the final one, zero-pads short
//                frames, drops surplus bytes of long frames, reports status.
//  Ports       : clk, RESETn (sync, active-low)
//                bus (slave modport): frame_sync, cmd_start/stop/cont,
//                s_tdata/tvalid/tready, m_tdata/tvalid/tready/tlast,
//                busy, frame_cnt, err_short, err_long
//  Revision    : 1.0  initial release
// ============================================================================
module frame_capture_ctrl
    import frame_capture_ctrl_pkg::*;
#(
    parameter int FRAME_BYTES = c_frame_bytes_default,
    parameter int CNT_W       = 20,
    parameter int FCNT_W      = 16
) (
    input wire logic             clk,
    input wire logic             RESETn,
    frame_capture_ctrl_if.slave  bus
);

    cap_state_t        r_state;
    logic              r_cont;
    logic              r_stop_pend;
    logic              r_err_short;
    logic              r_err_long;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic       w_is_last;
    logic       w_in_frame;
    logic       w_beat;
    logic       w_last_beat;
    logic       w_cnt_clear;
    logic       w_end_run;
    logic       w_s_tready;
    logic       w_m_tvalid;
    logic [7:0] w_m_tdata;
    logic       w_m_tlast;

    // ------------------------------------------------------------------
    // Output mux: pass-through in CAPTURE, zero bytes in PAD, discard else
    // ------------------------------------------------------------------
    always_comb begin
        w_s_tready = 1'b1;
        w_m_tvalid = 1'b0;
        w_m_tdata  = 8'h00;
        w_m_tlast  = 1'b0;
        case (r_state)
            ST_CAPTURE: begin
                w_m_tvalid = bus.s_tvalid;
                w_s_tready = bus.m_tready;
                w_m_tdata  = bus.s_tdata;
                w_m_tlast  = w_is_last;
            end
            ST_PAD: begin
                // Source is held off so its next-frame bytes wait for us
                w_s_tready = 1'b0;
                w_m_tvalid = 1'b1;
                w_m_tlast  = w_is_last;
            end
            default: ;
        endcase
    end

    assign w_in_frame  = (r_state == ST_CAPTURE) || (r_state == ST_PAD);
    assign w_beat      = w_m_tvalid & bus.m_tready;
    assign w_last_beat = w_beat & w_is_last;
    // Counter rests at zero outside a frame and rewinds on every completed
    // frame, so any entry into CAPTURE starts from byte 0.
    assign w_cnt_clear = !w_in_frame || w_last_beat;
    // A stop in the completing cycle itself also ends the run.
    assign w_end_run   = r_stop_pend | bus.cmd_stop | ~r_cont;

    frame_capture_ctrl_byte_counter #(
        .FRAME_BYTES (FRAME_BYTES),
        .CNT_W       (CNT_W)
    ) u_byte_counter (
        .clk       (clk),
        .RESETn    (RESETn),
        .i_clear   (w_cnt_clear),
        .i_en      (w_beat),
        .o_is_last (w_is_last)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_state     <= ST_IDLE;
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_start && !bus.cmd_stop) begin
                        r_state     <= ST_ARMED;
                        r_cont      <= bus.cmd_cont;
                        r_stop_pend <= 1'b0;
                        r_err_short <= 1'b0;
                        r_err_long  <= 1'b0;
                        r_frame_cnt <= '0;
                    end
                end
                ST_ARMED: begin
                    if (bus.cmd_stop) begin
                        r_state <= ST_IDLE;
                    end else if (bus.frame_sync) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.cmd_stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_last_beat) begin
                        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                        if (w_end_run) begin
                            r_state <= ST_IDLE;
                        end else if (bus.frame_sync) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (bus.frame_sync) begin
                        // Early VSYNC: finish this frame with zeros; that
                        // sync also opens the next frame.
                        r_err_short <= 1'b1;
                        r_state     <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (bus.cmd_stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_last_beat) begin
                        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                        r_state     <= w_end_run ? ST_IDLE : ST_CAPTURE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.s_tvalid) begin
                        r_err_long <= 1'b1;
                    end
                    if (bus.cmd_stop) begin
                        r_state <= ST_IDLE;
                    end else if (bus.frame_sync) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_tready  = w_s_tready;
    assign bus.m_tvalid  = w_m_tvalid;
    assign bus.m_tdata   = w_m_tdata;
    assign bus.m_tlast   = w_m_tlast;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.err_short = r_err_short;
    assign bus.err_long  = r_err_long;

endmodule : frame_capture_ctrl
`default_nettype wire

// File: tb/tb_frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_capture_ctrl
//  Description : Self-checking bench for frame_capture_ctrl with an 8-byte
//                frame. A reference model turns each frame's delivered source
//                bytes into the expected DMA byte stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_capture_ctrl;

    localparam int FB = 8;

    typedef logic [7:0] byteq_t[$];

    logic clk = 1'b0;
    logic RESETn;

    always #5 clk = ~clk;

    frame_capture_ctrl_if #(.FCNT_W(16)) bus ();

    frame_capture_ctrl #(
        .FRAME_BYTES (FB),
        .CNT_W       (4),
        .FCNT_W      (16)
    ) dut (
        .clk    (clk),
        .RESETn (RESETn),
        .bus    (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  src_q[$];
    logic [8:0]  out_q[$];
    logic [8:0]  exp_q[$];
    bit          gap_en;
    bit          bp_en;
    bit          prev_stall;
    logic [8:0]  prev_beat;
    byteq_t      fr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe at the falling edge, update drivers just after the rising edge.
    task automatic step();
        bit acc;
        @(negedge clk);
        acc = bus.s_tvalid & bus.s_tready;
        if (prev_stall && RESETn) begin
            chk("stall_valid", 32'(bus.m_tvalid), 32'd1);
            chk("stall_data", 32'({bus.m_tlast, bus.m_tdata}), 32'(prev_beat));
        end
        if (bus.m_tvalid && bus.m_tready && RESETn)
            out_q.push_back({bus.m_tlast, bus.m_tdata});
        prev_stall = bus.m_tvalid & ~bus.m_tready & RESETn;
        prev_beat  = {bus.m_tlast, bus.m_tdata};
        @(posedge clk);
        #1;
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        if (!(bus.s_tvalid && !acc))
            bus.s_tvalid = (src_q.size() > 0) && (!gap_en || $urandom_range(3) != 0);
        bus.s_tdata  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        bus.m_tready = bp_en ? 1'($urandom_range(1)) : 1'b1;
    endtask

    task automatic pulse_start(input bit cont);
        bus.cmd_start = 1'b1;
        bus.cmd_cont  = cont;
        step();
        bus.cmd_start = 1'b0;
        bus.cmd_cont  = 1'b0;
    endtask

    task automatic pulse_sync();
        bus.frame_sync = 1'b1;
        step();
        bus.frame_sync = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.cmd_stop = 1'b1;
        step();
        bus.cmd_stop = 1'b0;
    endtask

    task automatic push_bytes(input int n, output byteq_t sent);
        logic [7:0] b;
        sent = {};
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            src_q.push_back(b);
        end
    endtask

    // Reference model: a frame on the DMA side is the first FB bytes the
    // source delivered inside it, zero-filled to FB, tlast on the FB-th.
    task automatic expect_frame(input byteq_t delivered);
        for (int i = 0; i < FB; i++)
            exp_q.push_back({(i == FB - 1), (i < delivered.size()) ? delivered[i] : 8'h00});
    endtask

    task automatic run_until_out(input int n);
        int budget = 400;
        while (out_q.size() < n && budget > 0) begin
            step();
            budget--;
        end
        chk("out_timeout", 32'(out_q.size() >= n), 32'd1);
    endtask

    task automatic run_until_src(input int left);
        int budget = 400;
        while (src_q.size() > left && budget > 0) begin
            step();
            budget--;
        end
        chk("src_timeout", 32'(src_q.size() <= left), 32'd1);
    endtask

    task automatic compare_out(input string tag);
        chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < out_q.size()) chk(tag, 32'(out_q[i]), 32'(exp_q[i]));
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        RESETn         = 1'b0;
        bus.frame_sync = 1'b0;
        bus.cmd_start  = 1'b0;
        bus.cmd_stop   = 1'b0;
        bus.cmd_cont   = 1'b0;
        bus.s_tdata    = 8'h00;
        bus.s_tvalid   = 1'b0;
        bus.m_tready   = 1'b1;
        gap_en         = 1'b0;
        bp_en          = 1'b0;
        prev_stall     = 1'b0;
        prev_beat      = '0;
        repeat (3) step();
        RESETn = 1'b1;
        step();

        // Reset state
        chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(bus.m_tlast), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_s_tready", 32'(bus.s_tready), 32'd1);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_err_short", 32'(bus.err_short), 32'd0);
        chk("rst_err_long", 32'(bus.err_long), 32'd0);

        // 1: single frame
        gap_en = 1'b1;
        pulse_start(1'b0);
        step();
        pulse_sync();
        push_bytes(FB, fr);
        expect_frame(fr);
        run_until_out(FB);
        repeat (3) step();
        compare_out("s1_data");
        chk("s1_busy", 32'(bus.busy), 32'd0);
        chk("s1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("s1_err_short", 32'(bus.err_short), 32'd0);
        chk("s1_err_long", 32'(bus.err_long), 32'd0);

        // 2: short frame padded, next frame normal
        pulse_start(1'b1);
        pulse_sync();
        push_bytes(5, fr);
        expect_frame(fr);
        run_until_src(0);
        pulse_sync();
        push_bytes(FB, fr);
        expect_frame(fr);
        run_until_out(2 * FB);
        repeat (3) step();
        compare_out("s2_data");
        chk("s2_err_short", 32'(bus.err_short), 32'd1);
        chk("s2_err_long", 32'(bus.err_long), 32'd0);
        chk("s2_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        chk("s2_busy_drain", 32'(bus.busy), 32'd1);
        pulse_stop();
        chk("s2_busy_stop", 32'(bus.busy), 32'd0);

        // 3: long frame, surplus dropped
        pulse_start(1'b1);
        chk("s3_err_cleared", 32'(bus.err_short), 32'd0);
        pulse_sync();
        push_bytes(FB + 3, fr);
        expect_frame(fr);
        run_until_src(0);
        repeat (3) step();
        compare_out("s3_data");
        chk("s3_err_long", 32'(bus.err_long), 32'd1);
        chk("s3_err_short", 32'(bus.err_short), 32'd0);
        chk("s3_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        pulse_stop();

        // 4: backpressure across CAPTURE and PAD
        bp_en = 1'b1;
        pulse_start(1'b1);
        pulse_sync();
        push_bytes(5, fr);
        expect_frame(fr);
        run_until_src(0);
        pulse_sync();
        push_bytes(FB, fr);
        expect_frame(fr);
        run_until_out(2 * FB);
        repeat (3) step();
        compare_out("s4_data");
        chk("s4_err_short", 32'(bus.err_short), 32'd1);
        chk("s4_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        pulse_stop();
        bp_en = 1'b0;
        step();

        // 5a: stop mid-frame finishes the frame
        gap_en = 1'b0;
        pulse_start(1'b1);
        pulse_sync();
        push_bytes(FB, fr);
        expect_frame(fr);
        run_until_src(FB - 3);
        pulse_stop();
        run_until_out(FB);
        repeat (3) step();
        compare_out("s5a_data");
        chk("s5a_busy", 32'(bus.busy), 32'd0);
        chk("s5a_frame_cnt", 32'(bus.frame_cnt), 32'd1);

        // 5b: last beat and sync coincide
        pulse_start(1'b1);
        pulse_sync();
        push_bytes(FB, fr);
        expect_frame(fr);
        run_until_src(1);
        bus.frame_sync = 1'b1;
        push_bytes(FB, fr);
        expect_frame(fr);
        step();
        bus.frame_sync = 1'b0;
        run_until_out(2 * FB);
        repeat (3) step();
        compare_out("s5b_data");
        chk("s5b_err_short", 32'(bus.err_short), 32'd0);
        chk("s5b_err_long", 32'(bus.err_long), 32'd0);
        chk("s5b_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        pulse_stop();

        // 6: reset at byte 4 of the second frame
        pulse_start(1'b1);
        pulse_sync();
        push_bytes(FB, fr);
        expect_frame(fr);
        run_until_out(FB);
        repeat (2) step();
        compare_out("s6_first");
        pulse_sync();
        push_bytes(FB, fr);
        run_until_src(FB - 4);
        RESETn = 1'b0;
        step();
        chk("s6_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("s6_busy", 32'(bus.busy), 32'd0);
        chk("s6_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        src_q.delete();
        bus.s_tvalid = 1'b0;
        RESETn = 1'b1;
        out_q.delete();
        step();
        pulse_start(1'b0);
        pulse_sync();
        push_bytes(FB, fr);
        expect_frame(fr);
        run_until_out(FB);
        repeat (3) step();
        compare_out("s6_clean");
        chk("s6_frame_cnt_after", 32'(bus.frame_cnt), 32'd1);
        chk("s6_busy_after", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_frame_capture_ctrl
`default_nettype wire
